// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the SRAM memory controller: FSM encoding, default
// address window and SRAM bus widths.
package sram_mem_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC_LO = 3'd1,
    ST_ACC_HI = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam int          SRAM_DW           = 16;
  localparam int          WAIT_CNT_W        = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with a zero flag; stops at zero instead of wrapping.
module sram_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// Runs each 32-bit pipeline load/store as two 16-bit accesses to an
// asynchronous SRAM (low half first), followed by fixed wait states.
//
// Handshake: rd_en/wr_en are levels held by the pipeline until ready=1.
// ready is combinational and drops in the same cycle a request is seen in
// IDLE; it returns high only in DONE, where read_data is valid and the
// pipeline may advance. Requests are sampled only in IDLE.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          WAIT_CYCLES = 4,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t               state_q;
  logic                 is_write_q;
  logic [SRAM_AW-2:0]   word_q;
  logic [SRAM_DW-1:0]   wdata_hi_q;
  logic [31:0]          read_data_q;
  logic [SRAM_AW-1:0]   sram_addr_q;
  logic [SRAM_DW-1:0]   sram_dq_out_q;
  logic                 sram_dq_oe_q;
  logic                 sram_we_n_q;
  logic                 sram_oe_n_q;

  logic [31:0]          offset_d;
  logic [SRAM_AW-2:0]   word_d;
  logic                 req;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [WAIT_CNT_W-1:0] cnt_unused_value;
  logic                 unused_addr_bits;

  // Byte offset into the SRAM window; the low two bits select a byte and
  // anything above the SRAM size simply wraps.
  assign offset_d         = address - BASE_ADDR;
  assign word_d           = offset_d[SRAM_AW:2];
  assign unused_addr_bits = ^{offset_d[31:SRAM_AW+1], offset_d[1:0]};
  assign req              = rd_en | wr_en;

  assign cnt_load = (state_q == ST_ACC_HI);
  assign cnt_dec  = (state_q == ST_WAIT);

  sram_wait_counter #(
    .W(WAIT_CNT_W)
  ) u_wait_counter (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (cnt_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (cnt_dec),
    .count_o    (cnt_unused_value),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      is_write_q    <= 1'b0;
      word_q        <= '0;
      wdata_hi_q    <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            // Write wins when both requests are raised together.
            state_q     <= ST_ACC_LO;
            is_write_q  <= wr_en;
            word_q      <= word_d;
            wdata_hi_q  <= write_data[31:16];
            sram_addr_q <= {word_d, 1'b0};
            if (wr_en) begin
              sram_dq_out_q <= write_data[15:0];
              sram_dq_oe_q  <= 1'b1;
              sram_we_n_q   <= 1'b0;
            end else begin
              sram_oe_n_q   <= 1'b0;
            end
          end
        end
        ST_ACC_LO: begin
          state_q     <= ST_ACC_HI;
          sram_addr_q <= {word_q, 1'b1};
          if (is_write_q) begin
            sram_dq_out_q <= wdata_hi_q;
          end else begin
            read_data_q[15:0] <= sram_dq_in;
          end
        end
        ST_ACC_HI: begin
          state_q      <= ST_WAIT;
          sram_dq_oe_q <= 1'b0;
          sram_we_n_q  <= 1'b1;
          sram_oe_n_q  <= 1'b1;
          if (!is_write_q) begin
            read_data_q[31:16] <= sram_dq_in;
          end
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready       = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_oe_n   = sram_oe_n_q;

endmodule
